// File: rtl/seg_scan_scroller.sv
// Multiplexed seven-segment scan driver: one 8-bit segment bus time-shared across
// NUM_DIGITS one-hot selects, reading a writable pattern buffer from a scroll offset.
module seg_scan_scroller #(
  parameter int NUM_DIGITS    = 10,
  parameter int MSG_LEN       = 16,
  parameter int SCAN_DIV      = 1,
  parameter int SCROLL_FRAMES = 4,
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
`ifdef USE_POWER_PINS
  inout  wire                   vccd1,
  inout  wire                   vssd1,
`endif
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  scroll_en,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [7:0]            wr_data,
  output logic [NUM_DIGITS-1:0] sel,
  output logic [7:0]            segm,
  output logic                  frame_start
);

  localparam int AW1 = AW + 1;
  localparam int PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW  = $clog2(NUM_DIGITS);
  localparam int FW  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  localparam logic [PW-1:0]  P_LAST    = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0]  D_LAST    = DW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0]  F_LAST    = FW'(SCROLL_FRAMES - 1);
  localparam logic [AW-1:0]  O_LAST    = AW'(MSG_LEN - 1);
  localparam logic [AW1-1:0] MSG_LEN_W = AW1'(MSG_LEN);

  logic [PW-1:0]         p_q, p_d;
  logic [DW-1:0]         d_q, d_d;
  logic [AW-1:0]         o_q, o_d;
  logic [FW-1:0]         f_q, f_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [7:0]            segm_q, segm_d;
  logic                  frame_start_q, frame_start_d;
  logic [7:0]            mem_q [MSG_LEN];
  logic [7:0]            mem_d [MSG_LEN];

  logic                  tick;
  logic [AW1-1:0]        rd_sum;
  logic [AW-1:0]         rd_idx;
  logic [7:0]            rd_data;

  // o+d stays below 2*MSG_LEN, so a single conditional subtract replaces the modulo.
  always_comb begin
    tick    = en && (p_q == P_LAST);
    rd_sum  = AW1'(o_q) + AW1'(d_q);
    rd_idx  = (rd_sum >= MSG_LEN_W) ? AW'(rd_sum - MSG_LEN_W) : AW'(rd_sum);
    rd_data = mem_q[rd_idx];
  end

  always_comb begin
    p_d           = p_q;
    d_d           = d_q;
    o_d           = o_q;
    f_d           = f_q;
    sel_d         = sel_q;
    segm_d        = segm_q;
    frame_start_d = 1'b0;
    if (!en) begin
      sel_d  = '0;
      segm_d = '0;
    end else begin
      p_d = tick ? '0 : p_q + 1'b1;
      if (tick) begin
        sel_d         = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << d_q;
        segm_d        = rd_data;
        frame_start_d = (d_q == '0);
        if (d_q == D_LAST) begin
          d_d = '0;
          // Offset only moves at frame boundaries so a frame never mixes offsets.
          if (!scroll_en) begin
            f_d = '0;
          end else if (f_q == F_LAST) begin
            f_d = '0;
            o_d = (o_q == O_LAST) ? '0 : o_q + 1'b1;
          end else begin
            f_d = f_q + 1'b1;
          end
        end else begin
          d_d = d_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_en && ({1'b0, wr_addr} < MSG_LEN_W)) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q           <= '0;
      d_q           <= '0;
      o_q           <= '0;
      f_q           <= '0;
      sel_q         <= '0;
      segm_q        <= '0;
      frame_start_q <= 1'b0;
      for (int i = 0; i < MSG_LEN; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      p_q           <= p_d;
      d_q           <= d_d;
      o_q           <= o_d;
      f_q           <= f_d;
      sel_q         <= sel_d;
      segm_q        <= segm_d;
      frame_start_q <= frame_start_d;
      for (int i = 0; i < MSG_LEN; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign sel         = sel_q;
  assign segm        = segm_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_scroller.sv
// Directed bench: DUT A (10 digits, 10 entries, no prescale) and DUT B
// (10 digits, 16 entries, divide-by-3, scroll every 2 frames) share write/scroll inputs.
module tb_seg_scan_scroller;

  logic       clk;
  logic       rst_n;
  logic       en_a, en_b;
  logic       scroll_en;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  logic [9:0] sel_a, sel_b;
  logic [7:0] segm_a, segm_b;
  logic       fs_a, fs_b;

  int n_vec = 0;
  int n_err = 0;

  seg_scan_scroller #(
    .NUM_DIGITS(10), .MSG_LEN(10), .SCAN_DIV(1), .SCROLL_FRAMES(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .scroll_en(scroll_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sel(sel_a), .segm(segm_a), .frame_start(fs_a)
  );

  seg_scan_scroller #(
    .NUM_DIGITS(10), .MSG_LEN(16), .SCAN_DIV(3), .SCROLL_FRAMES(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .scroll_en(scroll_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sel(sel_b), .segm(segm_b), .frame_start(fs_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // drivers
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_mem(input logic [3:0] addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic check_b_tick(input string tag, input int dig, input int pat, input bit fs);
    check({tag, "_sel"}, 32'(sel_b), 32'(10'(1) << dig));
    check({tag, "_segm"}, 32'(segm_b), 32'(pat));
    check({tag, "_fs"}, 32'(fs_b), 32'(fs));
  endtask

  initial begin
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; scroll_en = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // reset state
    #1;
    check("rst_sel_a", 32'(sel_a), 0);
    check("rst_segm_a", 32'(segm_a), 0);
    check("rst_fs_a", 32'(fs_a), 0);
    check("rst_sel_b", 32'(sel_b), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // load C0..C9 while scan is disabled; addr 10 is out of range for A
    for (int i = 0; i < 10; i++) write_mem(4'(i), 8'(8'hC0 + i));
    write_mem(4'd10, 8'hEE);

    // static scan on A: a new digit every cycle
    en_a = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check("static_sel", 32'(sel_a), 32'(10'(1) << ((k - 1) % 10)));
      check("static_segm", 32'(segm_a), 32'(8'hC0 + ((k - 1) % 10)));
      check("static_fs", 32'(fs_a), 32'(((k - 1) % 10) == 0));
    end
    en_a = 1'b0;
    @(negedge clk);
    check("dis_sel_a", 32'(sel_a), 0);
    check("dis_segm_a", 32'(segm_a), 0);

    // prescale on B: first tick on edge 3, then every 3 edges
    en_b = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k < 3) begin
        check("pre_sel_idle", 32'(sel_b), 0);
        check("pre_segm_idle", 32'(segm_b), 0);
      end else begin
        check("pre_sel", 32'(sel_b), 32'(10'(1) << (((k - 3) / 3) % 10)));
        check("pre_segm", 32'(segm_b), 32'(8'hC0 + (((k - 3) / 3) % 10)));
        check("pre_fs", 32'(fs_b), 32'((k % 3 == 0) && ((((k - 3) / 3) % 10) == 0)));
      end
    end

    // asynchronous reset in the middle of a scan
    en_a = 1'b1;
    step(5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sel_a", 32'(sel_a), 0);
    check("mid_rst_segm_a", 32'(segm_a), 0);
    check("mid_rst_sel_b", 32'(sel_b), 0);
    check("mid_rst_segm_b", 32'(segm_b), 0);
    check("mid_rst_fs_b", 32'(fs_b), 0);
    en_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // buffer cleared by reset: every digit of A shows blank
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("clr_sel", 32'(sel_a), 32'(10'(1) << (k - 1)));
      check("clr_segm", 32'(segm_a), 0);
    end
    en_a = 1'b0;

    // scroll on B: mem[i]=i, offset advances every 2 frames
    for (int i = 0; i < 16; i++) write_mem(4'(i), 8'(i));
    en_b = 1'b1;
    scroll_en = 1'b1;
    for (int n = 0; n <= 32; n++) begin
      for (int j = 0; j < 10; j++) begin
        step(3);
        check_b_tick("scroll", j, ((n / 2) + j) % 16, j == 0);
      end
    end

    // enable gating on B: offset now 0 and held
    scroll_en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step(3);
      check_b_tick("pre_gate", j, j, j == 0);
    end
    step(1);
    en_b = 1'b0;
    step(1);
    check("gate_sel", 32'(sel_b), 0);
    check("gate_segm", 32'(segm_b), 0);
    check("gate_fs", 32'(fs_b), 0);
    step(1);
    check("gate_hold_sel", 32'(sel_b), 0);
    en_b = 1'b1;
    step(1);
    check("resume_wait_sel", 32'(sel_b), 0);
    step(1);
    check_b_tick("resume", 4, 4, 1'b0);
    step(3);
    check_b_tick("resume_next", 5, 5, 1'b0);

    // write collides with the read of digit 6 on its tick edge
    step(2);
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    check_b_tick("collide_old", 6, 6, 1'b0);
    for (int t = 0; t < 10; t++) begin
      int j;
      j = (7 + t) % 10;
      step(3);
      check_b_tick("collide_next", j, (j == 6) ? 8'hA5 : j, j == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
